// File: rtl/uart_rx_stream.sv
// uart_rx_stream
//   Oversampling 8N1 UART receiver feeding a byte FIFO, with paced output toward
//   the VT100 parser. Consecutive dataReady pulses are at least MIN_GAP cycles apart.
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   rxd        raw serial line, asynchronous, idle high
//   data       delivered byte; valid in the dataReady cycle, held until next pop
//   dataReady  one-cycle pulse per delivered byte
//   frameError one-cycle pulse when the stop bit is sampled low
//   overflow   sticky: a byte was dropped because the FIFO was full
//   fifoLevel  current FIFO occupancy
module uart_rx_stream #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MIN_GAP    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [7:0]                    data,
  output logic                          dataReady,
  output logic                          frameError,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

  localparam int unsigned TICK_RATE = BAUD * OVERSAMPLE;
  localparam int unsigned DIV_RAW   = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
  localparam int unsigned DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TC_W      = $clog2(OVERSAMPLE);
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GAP_W     = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [TC_W-1:0]  TC_MID     = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0]  TC_LAST    = TC_W'(OVERSAMPLE - 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rxState_e;

  logic             rxdMeta, rxdSync;
  logic [DIV_W-1:0] divCnt;
  logic             tick;

  rxState_e         state, stateNext;
  logic [TC_W-1:0]  tc, tcNext;
  logic [2:0]       bitIdx, bitNext;
  logic [7:0]       shiftReg, shiftNext;
  logic             pushReq, frameErrNext;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [GAP_W-1:0] gapCnt;
  logic             popReq, fifoFull, pushDo, overflowSet;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxdMeta <= 1'b1;
      rxdSync <= 1'b1;
    end else begin
      rxdMeta <= rxd;
      rxdSync <= rxdMeta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    divCnt <= '0;
    else if (divCnt == DIV_LAST) divCnt <= '0;
    else                         divCnt <= divCnt + 1'b1;
  end

  assign tick = (divCnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tc         <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      frameError <= 1'b0;
    end else begin
      state      <= stateNext;
      tc         <= tcNext;
      bitIdx     <= bitNext;
      shiftReg   <= shiftNext;
      frameError <= frameErrNext;
    end
  end

  always_comb begin
    stateNext    = state;
    tcNext       = tc;
    bitNext      = bitIdx;
    shiftNext    = shiftReg;
    pushReq      = 1'b0;
    frameErrNext = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!rxdSync) begin
            stateNext = ST_START;
            tcNext    = '0;
          end
        end
        ST_START: begin
          // Re-check mid start bit; a high sample means a glitch, dropped silently.
          if (tc == TC_MID) begin
            if (!rxdSync) begin
              stateNext = ST_DATA;
              tcNext    = '0;
              bitNext   = '0;
            end else begin
              stateNext = ST_IDLE;
            end
          end else begin
            tcNext = tc + 1'b1;
          end
        end
        ST_DATA: begin
          if (tc == TC_LAST) begin
            tcNext    = '0;
            shiftNext = {rxdSync, shiftReg[7:1]};
            if (bitIdx == 3'd7) stateNext = ST_STOP;
            else                bitNext   = bitIdx + 1'b1;
          end else begin
            tcNext = tc + 1'b1;
          end
        end
        ST_STOP: begin
          if (tc == TC_LAST) begin
            tcNext = '0;
            if (rxdSync) begin
              pushReq   = 1'b1;
              stateNext = ST_IDLE;
            end else begin
              frameErrNext = 1'b1;
              stateNext    = ST_BREAK;
            end
          end else begin
            tcNext = tc + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxdSync) stateNext = ST_IDLE;
        end
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  // A pop frees a slot on the same edge, so a push into a full FIFO that is
  // popping this cycle is accepted.
  assign popReq      = (fifoLevel != '0) && (gapCnt == '0);
  assign fifoFull    = (fifoLevel == LVL_FULL);
  assign pushDo      = pushReq && (!fifoFull || popReq);
  assign overflowSet = pushReq && fifoFull && !popReq;

  always_ff @(posedge clk) begin
    if (pushDo) mem[wrPtr] <= shiftReg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoLevel <= '0;
      gapCnt    <= '0;
      data      <= '0;
      dataReady <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      dataReady <= popReq;
      if (pushDo) wrPtr <= (wrPtr == PTR_LAST) ? '0 : wrPtr + 1'b1;
      if (popReq) begin
        rdPtr  <= (rdPtr == PTR_LAST) ? '0 : rdPtr + 1'b1;
        data   <= mem[rdPtr];
        gapCnt <= GAP_RELOAD;
      end else if (gapCnt != '0) begin
        gapCnt <= gapCnt - 1'b1;
      end
      case ({pushDo, popReq})
        2'b10:   fifoLevel <= fifoLevel + 1'b1;
        2'b01:   fifoLevel <= fifoLevel - 1'b1;
        default: fifoLevel <= fifoLevel;
      endcase
      if (overflowSet) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_stream.sv
module tb_uart_rx_stream;

  logic       clk = 1'b0;
  logic       rstA, rxdA, rstB, rxdB;
  logic [7:0] dataA, dataB;
  logic       readyA, readyB, feA, feB, ovA, ovB;
  logic [2:0] levelA, levelB;

  always #5 clk = ~clk;

  uart_rx_stream #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .FIFO_DEPTH(4), .MIN_GAP(8)
  ) dutA (
    .clk(clk), .rst(rstA), .rxd(rxdA), .data(dataA), .dataReady(readyA),
    .frameError(feA), .overflow(ovA), .fifoLevel(levelA)
  );

  uart_rx_stream #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .FIFO_DEPTH(4), .MIN_GAP(1000)
  ) dutB (
    .clk(clk), .rst(rstB), .rxd(rxdB), .data(dataB), .dataReady(readyB),
    .frameError(feB), .overflow(ovB), .fifoLevel(levelB)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cycle = 0;
  int unsigned rdyCntA = 0, rdyCntB = 0, feCntA = 0, feCntB = 0;
  int unsigned lastA = 0, lastB = 0;
  int unsigned minGapA = 32'hFFFF_FFFF, minGapB = 32'hFFFF_FFFF;
  logic [7:0]  qA[$];
  logic [7:0]  qB[$];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (readyA) begin
      if (rdyCntA > 0 && (cycle - lastA) < minGapA) minGapA = cycle - lastA;
      lastA = cycle;
      rdyCntA++;
      qA.push_back(dataA);
    end
    if (feA) feCntA++;
    if (readyB) begin
      if (rdyCntB > 0 && (cycle - lastB) < minGapB) minGapB = cycle - lastB;
      lastB = cycle;
      rdyCntB++;
      qB.push_back(dataB);
    end
    if (feB) feCntB++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic waitCycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setRxd(input int unsigned which, input logic v);
    if (which == 0) rxdA = v;
    else            rxdB = v;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; a low stop bit can be stretched.
  task automatic sendFrame(input int unsigned which, input logic [7:0] val,
                           input logic stopBit, input int unsigned extraLow);
    setRxd(which, 1'b0);
    waitCycles(16);
    for (int i = 0; i < 8; i++) begin
      setRxd(which, val[i]);
      waitCycles(16);
    end
    setRxd(which, stopBit);
    waitCycles(16);
    if (!stopBit && extraLow > 0) waitCycles(extraLow);
    setRxd(which, 1'b1);
  endtask

  typedef struct {
    logic [7:0]  val;
    logic        stopBit;
    int unsigned expReady;
    int unsigned expFe;
    logic [7:0]  expData;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int unsigned r0, f0;
    logic [7:0] partial;

    vecs[0] = '{8'h1B, 1'b1, 1, 0, 8'h1B};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[4] = '{8'h80, 1'b0, 0, 1, 8'hA5};
    vecs[5] = '{8'h01, 1'b1, 1, 0, 8'h01};

    rstA = 1'b0; rstB = 1'b0; rxdA = 1'b1; rxdB = 1'b1;
    waitCycles(3);
    chk("rst_dataA", 32'(dataA), 32'h0);
    chk("rst_readyA", 32'(readyA), 32'h0);
    chk("rst_feA", 32'(feA), 32'h0);
    chk("rst_ovA", 32'(ovA), 32'h0);
    chk("rst_levelA", 32'(levelA), 32'h0);
    chk("rst_levelB", 32'(levelB), 32'h0);
    chk("rst_ovB", 32'(ovB), 32'h0);
    rstA = 1'b1; rstB = 1'b1;
    waitCycles(5);

    // Single frames, including a bad stop bit that must not disturb held data.
    for (int v = 0; v < 6; v++) begin
      r0 = rdyCntA; f0 = feCntA;
      sendFrame(0, vecs[v].val, vecs[v].stopBit, 0);
      waitCycles(40);
      chk($sformatf("vec%0d_ready", v), rdyCntA - r0, vecs[v].expReady);
      chk($sformatf("vec%0d_fe", v), feCntA - f0, vecs[v].expFe);
      chk($sformatf("vec%0d_data", v), 32'(dataA), 32'(vecs[v].expData));
      chk($sformatf("vec%0d_level", v), 32'(levelA), 32'h0);
      chk($sformatf("vec%0d_ov", v), 32'(ovA), 32'h0);
    end

    // Back-to-back frames.
    r0 = rdyCntA;
    qA.delete();
    sendFrame(0, 8'h41, 1'b1, 0);
    sendFrame(0, 8'h42, 1'b1, 0);
    sendFrame(0, 8'h43, 1'b1, 0);
    waitCycles(40);
    chk("b2b_count", rdyCntA - r0, 32'd3);
    if (qA.size() >= 3) begin
      chk("b2b_byte0", 32'(qA[0]), 32'h41);
      chk("b2b_byte1", 32'(qA[1]), 32'h42);
      chk("b2b_byte2", 32'(qA[2]), 32'h43);
    end
    chk("b2b_hold", 32'(dataA), 32'h43);
    chk("b2b_gap_ge8", 32'(minGapA >= 8), 32'd1);

    // Short low glitch on an idle line.
    r0 = rdyCntA; f0 = feCntA;
    rxdA = 1'b0;
    waitCycles(4);
    rxdA = 1'b1;
    waitCycles(40);
    chk("glitch_ready", rdyCntA - r0, 32'd0);
    chk("glitch_fe", feCntA - f0, 32'd0);
    sendFrame(0, 8'h3C, 1'b1, 0);
    waitCycles(40);
    chk("glitch_next_ready", rdyCntA - r0, 32'd1);
    chk("glitch_next_data", 32'(dataA), 32'h3C);

    // Bad stop bit followed by a long break, then a good frame.
    r0 = rdyCntA; f0 = feCntA;
    sendFrame(0, 8'h55, 1'b0, 200);
    waitCycles(20);
    chk("break_fe", feCntA - f0, 32'd1);
    chk("break_ready", rdyCntA - r0, 32'd0);
    sendFrame(0, 8'h5A, 1'b1, 0);
    waitCycles(40);
    chk("break_fe_total", feCntA - f0, 32'd1);
    chk("break_next_ready", rdyCntA - r0, 32'd1);
    chk("break_next_data", 32'(dataA), 32'h5A);
    chk("break_level", 32'(levelA), 32'h0);

    // Reset in the middle of the data bits of 0x7E.
    r0 = rdyCntA;
    partial = 8'h7E;
    rxdA = 1'b0;
    waitCycles(16);
    for (int i = 0; i < 3; i++) begin
      rxdA = partial[i];
      waitCycles(16);
    end
    rstA = 1'b0;
    #1;
    chk("midrst_data", 32'(dataA), 32'h0);
    chk("midrst_ready", 32'(readyA), 32'h0);
    chk("midrst_fe", 32'(feA), 32'h0);
    chk("midrst_level", 32'(levelA), 32'h0);
    rxdA = 1'b1;
    waitCycles(5);
    rstA = 1'b1;
    waitCycles(200);
    chk("midrst_no_byte", rdyCntA - r0, 32'd0);
    sendFrame(0, 8'h20, 1'b1, 0);
    waitCycles(40);
    chk("midrst_next_ready", rdyCntA - r0, 32'd1);
    chk("midrst_next_data", 32'(dataA), 32'h20);

    // Overflow with a slow consumer.
    for (int i = 0; i < 6; i++) sendFrame(1, 8'(8'h30 + i), 1'b1, 0);
    waitCycles(10);
    chk("ovf_flag", 32'(ovB), 32'h1);
    chk("ovf_level", 32'(levelB), 32'd4);
    chk("ovf_first_count", rdyCntB, 32'd1);
    chk("ovf_first_data", 32'(dataB), 32'h30);
    for (int k = 0; k < 6000 && rdyCntB < 5; k++) waitCycles(1);
    chk("ovf_drain_count", rdyCntB, 32'd5);
    waitCycles(1100);
    chk("ovf_final_count", rdyCntB, 32'd5);
    if (qB.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("ovf_byte%0d", i), 32'(qB[i]), 32'(8'h30 + i));
    end
    chk("ovf_sticky", 32'(ovB), 32'h1);
    chk("ovf_level_end", 32'(levelB), 32'h0);
    chk("ovf_gap", minGapB, 32'd1000);
    chk("ovf_no_fe", feCntB, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
